// File: rtl/mem_access.sv
// Memory-access stage: turns the ALU result into a single-outstanding req/ack
// bus transaction, formats load/store data and pulses completion to writeback.
package mem_access_pkg;
  typedef struct packed {
    logic add;
    logic sub;
    logic lui;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions_t;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enabled,
  input  instructions_t instr,
  input  logic [31:0]   alu_result,
  input  logic [31:0]   rs2_v,
  output logic          busy,
  output logic          completed,
  output logic [31:0]   result,
  output logic          error,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic [4:0]  r_ld;        // {lb, lh, lw, lbu, lhu} of the accepted op
  logic [1:0]  r_off;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_result;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_unused;

  assign w_unused   = ^{instr.add, instr.sub, instr.lui};
  assign w_is_load  = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
  assign w_is_store = instr.sb | instr.sh | instr.sw;
  assign w_misaligned = ((instr.lh | instr.lhu | instr.sh) & alu_result[0]) |
                        ((instr.lw | instr.sw) & (|alu_result[1:0]));
  // Fires on the TIMEOUT-th REQ cycle; an ack in that same cycle takes priority.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_wdata = 32'd0;
    w_wstrb = 4'd0;
    if (instr.sb) begin
      w_wdata = {4{rs2_v[7:0]}};
      w_wstrb = 4'b0001 << alu_result[1:0];
    end else if (instr.sh) begin
      w_wdata = {2{rs2_v[15:0]}};
      w_wstrb = 4'b0011 << alu_result[1:0];
    end else if (instr.sw) begin
      w_wdata = rs2_v;
      w_wstrb = 4'b1111;
    end
  end

  assign w_byte = mem_rdata[8*r_off +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = 32'd0;
    case (1'b1)
      r_ld[4]: w_load_data = {{24{w_byte[7]}}, w_byte};
      r_ld[3]: w_load_data = {{16{w_half[15]}}, w_half};
      r_ld[2]: w_load_data = mem_rdata;
      r_ld[1]: w_load_data = {24'd0, w_byte};
      r_ld[0]: w_load_data = {16'd0, w_half};
      default: w_load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (enabled) begin
        if ((w_is_load | w_is_store) && !w_misaligned) w_next = S_REQ;
        else                                           w_next = S_DONE;
      end
      S_REQ:  if (mem_ack || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    completed = (r_state == S_DONE);
    error     = completed & r_err;
    mem_req   = (r_state == S_REQ);
    mem_we    = mem_req & r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_wstrb = r_wstrb;
    result    = r_result;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_cnt    <= '0;
      r_ld     <= '0;
      r_off    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (enabled) begin
          r_cnt <= '0;
          if (!(w_is_load | w_is_store)) begin
            r_result <= alu_result;
            r_err    <= 1'b0;
          end else if (w_misaligned) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            // Bus-facing registers only move when a transaction is launched.
            r_ld    <= {instr.lb, instr.lh, instr.lw, instr.lbu, instr.lhu};
            r_off   <= alu_result[1:0];
            r_we    <= w_is_store;
            r_addr  <= {alu_result[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_result <= w_load_data;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, randomized transactions against
// an arithmetic reference model, and hand-written reset/busy sequences.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  typedef enum int {K_ADD, K_SUB, K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW} kind_t;

  typedef struct {
    string       tag;
    kind_t       k;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          ack_at;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_cyc;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enabled;
  instructions_t instr;
  logic [31:0]   alu_result;
  logic [31:0]   rs2_v;
  logic          busy;
  logic          completed;
  logic [31:0]   result;
  logic          error;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .instr(instr),
    .alu_result(alu_result), .rs2_v(rs2_v), .busy(busy), .completed(completed),
    .result(result), .error(error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instructions_t mk_instr(input kind_t k);
    instructions_t i;
    i = '0;
    case (k)
      K_ADD: i.add = 1'b1;
      K_SUB: i.sub = 1'b1;
      K_LB:  i.lb  = 1'b1;
      K_LH:  i.lh  = 1'b1;
      K_LW:  i.lw  = 1'b1;
      K_LBU: i.lbu = 1'b1;
      K_LHU: i.lhu = 1'b1;
      K_SB:  i.sb  = 1'b1;
      K_SH:  i.sh  = 1'b1;
      default: i.sw = 1'b1;
    endcase
    return i;
  endfunction

  function automatic bit is_store(input kind_t k);
    return (k == K_SB) || (k == K_SH) || (k == K_SW);
  endfunction

  // Reference model built from access size, byte offset and plain arithmetic.
  function automatic vec_t model(input kind_t k, input logic [31:0] addr, rs2, rdata,
                                 input int ack_at);
    vec_t v;
    int size;
    int off;
    logic [31:0] byte_v, half_v;
    v = '{"rand", k, addr, rs2, rdata, ack_at, 32'd0, 1'b0, 0, 4'd0, 32'd0};
    off = int'(addr % 4);
    case (k)
      K_LB, K_LBU, K_SB: size = 1;
      K_LH, K_LHU, K_SH: size = 2;
      K_LW, K_SW:        size = 4;
      default:           size = 0;
    endcase
    if (size == 0) begin
      v.exp_res = addr;
      return v;
    end
    if ((addr % size) != 0) begin
      v.exp_err = 1'b1;
      return v;
    end
    if (is_store(k)) begin
      v.exp_wstrb = 4'(((1 << size) - 1) << off);
      if (size == 1)      v.exp_wdata = (rs2 & 32'hFF) * 32'h0101_0101;
      else if (size == 2) v.exp_wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
      else                v.exp_wdata = rs2;
    end
    if (ack_at == 0 || ack_at > TO) begin
      v.exp_cyc = TO;
      v.exp_err = 1'b1;
      return v;
    end
    v.exp_cyc = ack_at;
    byte_v = (rdata >> (8 * off)) & 32'hFF;
    half_v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (k)
      K_LB:  v.exp_res = (byte_v >= 128) ? byte_v - 32'd256 : byte_v;
      K_LBU: v.exp_res = byte_v;
      K_LH:  v.exp_res = (half_v >= 32768) ? half_v - 32'd65536 : half_v;
      K_LHU: v.exp_res = half_v;
      K_LW:  v.exp_res = rdata;
      default: v.exp_res = 32'd0;
    endcase
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int cyc;
    logic stable;
    logic early;
    logic [68:0] snap;
    cyc = 0;
    stable = 1'b1;
    early = 1'b0;
    snap = '0;
    instr = mk_instr(v.k);
    alu_result = v.addr;
    rs2_v = v.rs2;
    enabled = 1'b1;
    step();
    enabled = 1'b0;
    instr = '0;
    alu_result = $urandom;
    rs2_v = $urandom;
    while (mem_req && cyc < 20) begin
      cyc++;
      if (cyc == 1) begin
        chk({v.tag, "_addr"}, mem_addr, v.addr & ~32'd3);
        chk({v.tag, "_we"}, 32'(mem_we), 32'(is_store(v.k)));
        chk({v.tag, "_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
        if (is_store(v.k)) chk({v.tag, "_wdata"}, mem_wdata, v.exp_wdata);
        snap = {mem_addr, mem_wdata, mem_wstrb, mem_we};
      end else if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== snap) begin
        stable = 1'b0;
      end
      if (completed || !busy) early = 1'b1;
      if (cyc == v.ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    chk({v.tag, "_req_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.tag, "_bus_stable"}, 32'(stable), 32'd1);
    chk({v.tag, "_busy_in_req"}, 32'(early), 32'd0);
    chk({v.tag, "_completed"}, 32'(completed), 32'd1);
    chk({v.tag, "_error"}, 32'(error), 32'(v.exp_err));
    if (!v.exp_err || v.exp_cyc != 0) chk({v.tag, "_result"}, result, v.exp_res);
    step();
    chk({v.tag, "_pulse_end"}, 32'(completed), 32'd0);
    chk({v.tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[14];
    vec_t v;
    rstn = 1'b1;
    enabled = 1'b0;
    instr = '0;
    alu_result = '0;
    rs2_v = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) step();
    rstn = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_completed", 32'(completed), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);

    vecs[0]  = '{"add", K_ADD, 32'h0000_1234, 32'h0, 32'h0, 0, 32'h0000_1234, 1'b0, 0, 4'h0, 32'h0};
    vecs[1]  = '{"lb", K_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 32'hFFFF_FF80, 1'b0, 3, 4'h0, 32'h0};
    vecs[2]  = '{"lbu", K_LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 32'h0000_0080, 1'b0, 3, 4'h0, 32'h0};
    vecs[3]  = '{"sh", K_SH, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 1, 32'h0, 1'b0, 1, 4'b1100, 32'hBEEF_BEEF};
    vecs[4]  = '{"lw_mis", K_LW, 32'h0000_0001, 32'h0, 32'h0, 0, 32'h0, 1'b1, 0, 4'h0, 32'h0};
    vecs[5]  = '{"sw_tmo", K_SW, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 32'h0, 1'b1, 4, 4'hF, 32'hCAFE_F00D};
    vecs[6]  = '{"sw_ack4", K_SW, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 4, 32'h0, 1'b0, 4, 4'hF, 32'hCAFE_F00D};
    vecs[7]  = '{"lh", K_LH, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 2, 32'hFFFF_8001, 1'b0, 2, 4'h0, 32'h0};
    vecs[8]  = '{"lhu", K_LHU, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 2, 32'h0000_7FFF, 1'b0, 2, 4'h0, 32'h0};
    vecs[9]  = '{"sb", K_SB, 32'h0000_0301, 32'h1234_56AB, 32'h0, 1, 32'h0, 1'b0, 1, 4'b0010, 32'hABAB_ABAB};
    vecs[10] = '{"lh_mis", K_LH, 32'h0000_0005, 32'h0, 32'h0, 0, 32'h0, 1'b1, 0, 4'h0, 32'h0};
    vecs[11] = '{"lw", K_LW, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 1, 4'h0, 32'h0};
    vecs[12] = '{"sub", K_SUB, 32'hFFFF_0000, 32'h0, 32'h0, 0, 32'hFFFF_0000, 1'b0, 0, 4'h0, 32'h0};
    vecs[13] = '{"lb_pos", K_LB, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1, 32'h0000_007F, 1'b0, 1, 4'h0, 32'h0};
    for (int i = 0; i < 14; i++) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      v = model(kind_t'($urandom_range(0, 9)), $urandom & 32'h0000_FFFF, $urandom, $urandom,
                int'($urandom_range(0, 6)));
      run_txn(v);
    end

    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_completed", 32'(completed), 32'd0);

    // Enable pulsed while a load is outstanding must not start a second op.
    instr = mk_instr(K_LB);
    alu_result = 32'h0000_0103;
    enabled = 1'b1;
    step();
    instr = mk_instr(K_ADD);
    alu_result = 32'h0000_5555;
    chk("busy_req1", 32'(mem_req), 32'd1);
    step();
    enabled = 1'b0;
    chk("busy_req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h80FF_0000;
    step();
    mem_ack = 1'b0;
    chk("busy_done", 32'(completed), 32'd1);
    chk("busy_result", result, 32'hFFFF_FF80);
    step();
    chk("busy_no_req", 32'(mem_req), 32'd0);
    chk("busy_no_busy", 32'(busy), 32'd0);
    step();
    chk("busy_no_second", 32'(completed), 32'd0);

    // Reset while a request is outstanding.
    instr = mk_instr(K_LW);
    alu_result = 32'h0000_0080;
    enabled = 1'b1;
    step();
    enabled = 1'b0;
    chk("rreq_req1", 32'(mem_req), 32'd1);
    step();
    chk("rreq_req2", 32'(mem_req), 32'd1);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    chk("rreq_req_low", 32'(mem_req), 32'd0);
    chk("rreq_busy_low", 32'(busy), 32'd0);
    chk("rreq_no_done", 32'(completed), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("rreq_late_ack_done", 32'(completed), 32'd0);
    chk("rreq_late_ack_busy", 32'(busy), 32'd0);
    chk("rreq_result", result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
